// File: rtl/seq_player.sv
// Sequence playback engine: replays the stored colour sequence on the LEDs,
// oldest item first, pacing each item and gap on the game-rate tick.
module seq_player #(
  parameter int P_SEQ_W     = 64,
  parameter int P_NIB       = 4,
  parameter int P_RND_W     = 4,
  parameter int P_ON_TICKS  = 1,
  parameter int P_GAP_TICKS = 1
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               start,
  input  logic [P_SEQ_W-1:0] seq,
  input  logic [P_RND_W-1:0] round,
  output logic [P_NIB-1:0]   leds,
  output logic               busy,
  output logic               done,
  output logic [P_RND_W-1:0] step
);

  localparam int P_ITEMS = P_SEQ_W / P_NIB;
  localparam int P_IDX_W = P_RND_W + 1;

  localparam logic [P_IDX_W-1:0] L_ITEMS = P_IDX_W'(P_ITEMS);
  localparam logic [P_IDX_W-1:0] L_ONE   = P_IDX_W'(1);
  localparam logic [3:0]         L_ON    = 4'(P_ON_TICKS - 1);
  localparam logic [3:0]         L_GAP   = 4'(P_GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [P_SEQ_W-1:0]   r_seq;
  logic [P_IDX_W-1:0]   r_n;
  logic [P_RND_W-1:0]   r_step;
  logic [3:0]           r_cnt;
  logic [P_NIB-1:0]     r_leds;
  logic                 r_busy;
  logic                 r_done;

  logic [P_IDX_W-1:0]   w_n_in;
  logic [P_IDX_W-1:0]   w_start_idx;
  logic [P_IDX_W-1:0]   w_next_idx;
  logic                 w_last;

  // Items are packed newest-at-top, so the oldest of N items sits at index
  // ITEMS-N; one extra index bit keeps N=16 from wrapping to zero.
  assign w_n_in      = {1'b0, round} + L_ONE;
  assign w_start_idx = L_ITEMS - w_n_in;
  assign w_next_idx  = L_ITEMS - r_n + {1'b0, r_step} + L_ONE;
  assign w_last      = ({1'b0, r_step} == (r_n - L_ONE));

  function automatic logic [P_NIB-1:0] f_item(input logic [P_SEQ_W-1:0] s,
                                              input logic [P_IDX_W-1:0] idx);
    f_item = '0;
    for (int i = 0; i < P_ITEMS; i++) begin
      if (idx == P_IDX_W'(i)) f_item = s[i*P_NIB +: P_NIB];
    end
  endfunction

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values; a later assignment in the same branch
  // simply overrides an earlier default.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_n     <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_leds  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_leds <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_seq   <= seq;
            r_n     <= w_n_in;
            r_step  <= '0;
            r_cnt   <= '0;
            r_leds  <= f_item(seq, w_start_idx);
            r_busy  <= 1'b1;
            r_state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (tick) begin
            if (r_cnt == L_ON) begin
              r_cnt   <= '0;
              r_leds  <= '0;
              r_state <= S_GAP;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (r_cnt == L_GAP) begin
              r_cnt <= '0;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_step  <= r_step + P_RND_W'(1);
                r_leds  <= f_item(r_seq, w_next_idx);
                r_state <= S_SHOW;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_leds  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign leds = r_leds;
  assign busy = r_busy;
  assign done = r_done;
  assign step = r_step;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: two instances (default and 3/2 tick timing) checked
// against a tick-position model of the playback timeline.
module tb_seq_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic        start_a, start_b;
  logic [63:0] seq;
  logic [3:0]  round;
  logic [3:0]  leds_a, leds_b, step_a, step_b;
  logic        busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_player u_a (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .start(start_a),
    .seq(seq), .round(round),
    .leds(leds_a), .busy(busy_a), .done(done_a), .step(step_a)
  );

  seq_player #(.P_ON_TICKS(3), .P_GAP_TICKS(2)) u_b (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .start(start_b),
    .seq(seq), .round(round),
    .leds(leds_b), .busy(busy_b), .done(done_b), .step(step_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input int sel, input string tag, input logic [3:0] el,
                             input logic eb, input logic ed, input logic [3:0] es);
    logic [3:0] l, s;
    logic       b, d;
    if (sel == 0) begin l = leds_a; b = busy_a; d = done_a; s = step_a; end
    else          begin l = leds_b; b = busy_b; d = done_b; s = step_b; end
    check({tag, "/leds"}, 32'(l), 32'(el));
    check({tag, "/busy"}, 32'(b), 32'(eb));
    check({tag, "/done"}, 32'(d), 32'(ed));
    check({tag, "/step"}, 32'(s), 32'(es));
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Expected outputs once p ticks have been counted since start: each item
  // occupies on+gap tick slots, lit for the first 'on' of them.
  task automatic model_exp(input logic [63:0] s, input int n, input int on, input int gap,
                           input int p, output logic [3:0] el, output logic eb,
                           output logic ed, output logic [3:0] es);
    int total, k, ph;
    total = n * (on + gap);
    if (p >= total) begin
      el = 4'h0; eb = 1'b0; ed = 1'b1; es = 4'(n - 1);
    end else begin
      k  = p / (on + gap);
      ph = p % (on + gap);
      el = (ph < on) ? s[4*(16-n+k) +: 4] : 4'h0;
      eb = 1'b1; ed = 1'b0; es = 4'(k);
    end
  endtask

  task automatic play(input int sel, input logic [63:0] s, input int r, input int idle_fixed,
                      input bit with_tick, input bit mutate, input string name);
    int on, gap, n, total, idle;
    logic [3:0] el, es;
    logic       eb, ed;
    on    = (sel == 0) ? 1 : 3;
    gap   = (sel == 0) ? 1 : 2;
    n     = r + 1;
    total = n * (on + gap);
    seq   = s;
    round = r[3:0];
    tick  = with_tick;
    set_start(sel, 1'b1);
    cyc();
    set_start(sel, 1'b0);
    tick = 1'b0;
    model_exp(s, n, on, gap, 0, el, eb, ed, es);
    check_state(sel, $sformatf("%s/p0", name), el, eb, ed, es);
    for (int p = 1; p <= total; p++) begin
      idle = (idle_fixed >= 0) ? idle_fixed : int'($urandom_range(0, 3));
      for (int i = 0; i < idle; i++) begin
        if (mutate) begin
          seq   = {$urandom, $urandom};
          round = 4'($urandom);
          set_start(sel, 1'($urandom_range(0, 1)));
        end
        cyc();
        model_exp(s, n, on, gap, p - 1, el, eb, ed, es);
        check_state(sel, $sformatf("%s/hold%0d", name, p - 1), el, eb, ed, es);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      set_start(sel, 1'b0);
      model_exp(s, n, on, gap, p, el, eb, ed, es);
      check_state(sel, $sformatf("%s/p%0d", name, p), el, eb, ed, es);
    end
    if (mutate) set_start(sel, 1'b1);
    cyc();
    set_start(sel, 1'b0);
    check_state(sel, $sformatf("%s/end", name), 4'h0, 1'b0, 1'b0, 4'(n - 1));
    cyc();
    check_state(sel, $sformatf("%s/idle", name), 4'h0, 1'b0, 1'b0, 4'(n - 1));
  endtask

  initial begin
    logic [63:0] s;
    logic [3:0]  el, es;
    logic        eb, ed;

    reset_n = 1'b0;
    tick    = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    seq     = '0;
    round   = '0;
    #1;
    check_state(0, "rst_a", 4'h0, 1'b0, 1'b0, 4'h0);
    check_state(1, "rst_b", 4'h0, 1'b0, 1'b0, 4'h0);
    cyc();
    cyc();
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      tick = 1'(i % 2);
      cyc();
      check_state(0, $sformatf("idle_a%0d", i), 4'h0, 1'b0, 1'b0, 4'h0);
    end
    tick = 1'b0;

    // Three items, tick every 8 cycles: expect 1,0,2,0,4,0 then done.
    play(0, 64'h4210_0000_0000_0000, 2, 7, 1'b0, 1'b0, "three");

    s = {4'h8, 60'($urandom), 32'($urandom)};
    s[63:60] = 4'h8;
    play(0, s, 0, -1, 1'b0, 1'b0, "single");

    play(0, 64'h0123_4567_89AB_CDEF, 15, -1, 1'b0, 1'b0, "full");

    for (int t = 0; t < 4; t++) begin
      play(0, {$urandom, $urandom}, int'($urandom_range(0, 15)), -1, 1'b0, 1'b1,
           $sformatf("rnd_a%0d", t));
    end

    play(1, {$urandom, $urandom}, 1, -1, 1'b1, 1'b0, "timing_b");
    for (int t = 0; t < 2; t++) begin
      play(1, {$urandom, $urandom}, int'($urandom_range(0, 6)), -1, t[0], 1'b1,
           $sformatf("rnd_b%0d", t));
    end

    // Abandon a playback mid-SHOW with an asynchronous reset.
    s       = {$urandom, $urandom};
    seq     = s;
    round   = 4'd3;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    cyc();
    model_exp(s, 4, 1, 1, 0, el, eb, ed, es);
    check_state(0, "pre_rst", el, eb, ed, es);
    #2;
    reset_n = 1'b0;
    #1;
    check_state(0, "async_rst", 4'h0, 1'b0, 1'b0, 4'h0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick = 1'(~i[0]);
      cyc();
      check_state(0, $sformatf("post_rst%0d", i), 4'h0, 1'b0, 1'b0, 4'h0);
    end
    tick = 1'b0;

    play(0, {$urandom, $urandom}, int'($urandom_range(0, 15)), -1, 1'b1, 1'b1, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Plays the stored FPGA colour sequence back to the player on the LEDs, oldest item first, at the game rate.
- Reads the 64-bit sequence register, which is written by shifting each new 4-bit item in at bits [63:60].
- Sits between the FPGA sequence register and the LED outputs.
- Reports back to the control FSM with a busy level and a one-cycle done pulse.

Parameters:
- P_SEQ_W, 64, width of the sequence register; must equal P_NIB*16.
- P_NIB, 4, bits per sequence item (one-hot LED pattern).
- P_RND_W, 4, width of the round number.
- P_ON_TICKS, 1, number of tick pulses an item stays lit (1..15).
- P_GAP_TICKS, 1, number of tick pulses LEDs are dark between items (1..15).

Ports:
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- tick  input  1  single-cycle enable at the selected game rate; already synchronous to CLOCK_50.
- start  input  1  request playback; sampled only in IDLE.
- seq  input  P_SEQ_W  sequence register contents; newest item at [63:60].
- round  input  P_RND_W  current round; item count N = round+1 (1..16).
- leds  output  P_NIB  registered LED drive.
- busy  output  1  high in SHOW and GAP.
- done  output  1  one-cycle pulse when the last gap ends.
- step  output  P_RND_W  index of the item being shown (0 = oldest).

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: leds=0, busy=0, done=0, step=0.
  - State goes to IDLE; internal counters go to 0.
  - Reset during SHOW or GAP abandons playback immediately.
- States: IDLE, SHOW, GAP, DONE.
- IDLE:
  - leds=0, busy=0.
  - If start=1 on an edge:
    - Snapshot seq into an internal copy and latch N=round+1.
    - Set step=0 and the tick counter to 0.
    - Go to SHOW.
    - leds show item 0 from the next cycle, i.e. 1-cycle latency from start.
- Item addressing:
  - Item k (0..N-1) is the snapshot nibble at index 16-N+k, i.e. bits [4*(16-N+k)+3 : 4*(16-N+k)].
  - Index arithmetic is done in 5 bits, so there is no wrap when N=16.
  - Nibbles are driven to leds verbatim; no one-hot check.
- SHOW:
  - leds = item[step].
  - Each tick increments the tick counter.
  - On the tick that brings the count to P_ON_TICKS: clear the counter, set leds=0, go to GAP.
- GAP:
  - leds=0.
  - Ticks are counted the same way, up to P_GAP_TICKS.
  - On the terminal tick:
    - If step==N-1, go to DONE.
    - Otherwise increment step, clear the counter, go to SHOW.
- DONE:
  - done=1 for exactly one cycle; busy=0; leds=0.
  - Then go to IDLE. step holds N-1 until the next start.
- Cycles without tick leave the counter and state unchanged, so the LED pattern is stable for the whole interval.
- Boundary rules:
  - start while busy or in DONE: ignored; no restart.
  - start and tick in the same cycle in IDLE: the tick is not counted; counting begins from the next tick.
  - seq or round changing during playback: no effect, because the snapshot is used.
  - round=0: exactly one item (nibble 15) is shown.
  - round=15: all 16 nibbles are shown, nibble 0 first.
- Total playback time is N*(P_ON_TICKS+P_GAP_TICKS) ticks, plus the start and DONE cycles.

Test Plan:
- Reset and idle:
  - Stimulus: reset_n=0 mid-SHOW, then release; tick toggling with start=0.
  - Required: leds=0, busy=0, done=0, step=0 asynchronously on reset, and the block stays in IDLE.
- Three-item playback:
  - Stimulus: round=2, seq=64'h4210_0000_0000_0000, defaults, tick every 8 cycles.
  - Required: leds sequence 1,0,2,0,4,0; busy high for 6 ticks; done pulses once, 1 cycle after the 6th tick; step 0→1→2.
- Single and full length:
  - Stimulus: round=0 with seq[63:60]=8.
  - Required: one 8 flash, then done.
  - Stimulus: round=15, seq=64'h0123_4567_89AB_CDEF.
  - Required: leds show F,E,D,…,0 in that order, each followed by a gap; done after 32 ticks.
- Snapshot and restart protection:
  - Stimulus: change seq and round after start; pulse start mid-SHOW.
  - Required: the original items play unchanged and busy remains continuous.
- Timing parameters:
  - Stimulus: P_ON_TICKS=3, P_GAP_TICKS=2, round=1.
  - Required: each item lit exactly 3 ticks and dark 2 ticks; done after 10 ticks.
  - Stimulus: start coincident with tick.
  - Required: that tick is not counted.
